// File: rtl/sm_seq_pkg.sv
// rtl/sm_seq_pkg.sv - shared types and default widths for the move sequencer
package sm_seq_pkg;

  localparam int SEQ_SIZE       = 16;
  localparam int SEQ_CNT_W      = 16;
  localparam int SEQ_DWELL_W    = 16;
  localparam int SEQ_DEPTH      = 4;
  localparam int SEQ_MIN_PERIOD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_DWELL
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_DWELL_W-1:0] dwell;
    logic                   dir;
    logic [SEQ_CNT_W-1:0]   count;
    logic [SEQ_SIZE-1:0]    period;
  } seq_cmd_t;

endpackage

// File: rtl/sm_cmd_fifo.sv
// rtl/sm_cmd_fifo.sv - synchronous command FIFO with push/pop/flush and occupancy
module sm_cmd_fifo #(
  parameter int W     = 49,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/sm_move_sequencer.sv
// rtl/sm_move_sequencer.sv - sequences queued move segments onto the step pulse generator
// Define SM_SEQ_DWELL_EN to add the post-segment dwell pause (DWELL state and counter).
module sm_move_sequencer
  import sm_seq_pkg::*;
#(
  parameter int SIZE       = SEQ_SIZE,
  parameter int CNT_W      = SEQ_CNT_W,
  parameter int DWELL_W    = SEQ_DWELL_W,
  parameter int DEPTH      = SEQ_DEPTH,
  parameter int MIN_PERIOD = SEQ_MIN_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [SIZE-1:0]        cmd_period,
  input  logic [CNT_W-1:0]       cmd_count,
  input  logic                   cmd_dir,
  input  logic [DWELL_W-1:0]     cmd_dwell,
  input  logic                   hold,
  input  logic                   abort,
  output logic                   gen_start,
  output logic                   gen_stop,
  output logic [SIZE-1:0]        gen_period,
  output logic [CNT_W-1:0]       gen_count,
  output logic                   gen_dir,
  input  logic                   gen_done,
  output logic                   seg_done,
  output logic                   seq_busy,
  output logic                   clamp_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0]   FULL  = LW'(DEPTH);
  localparam logic [SIZE-1:0] MIN_P = SIZE'(MIN_PERIOD);
`ifdef SM_SEQ_DWELL_EN
  localparam int FW = DWELL_W + 1 + CNT_W + SIZE;
`else
  localparam int FW = 1 + CNT_W + SIZE;
`endif

  seq_state_e        state;
  seq_state_e        state_nxt;
  seq_state_e        after_seg;
  logic              push;
  logic              pop;
  logic              load_en;
  logic [LW-1:0]     lvl_nxt;
  logic [FW-1:0]     wdata;
  logic [FW-1:0]     rdata;
  logic [SIZE-1:0]   head_period;
  logic [CNT_W-1:0]  head_count;
  logic              head_dir;

`ifdef SM_SEQ_DWELL_EN
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  assign wdata     = {cmd_dwell, cmd_dir, cmd_count, cmd_period};
  assign after_seg = (dwell_q != '0) ? ST_DWELL : ST_IDLE;
`else
  logic unused_dwell;
  assign unused_dwell = ^cmd_dwell;
  assign wdata        = {cmd_dir, cmd_count, cmd_period};
  assign after_seg    = ST_IDLE;
`endif

  assign head_period = rdata[SIZE-1:0];
  assign head_count  = rdata[SIZE +: CNT_W];
  assign head_dir    = rdata[SIZE+CNT_W];

  assign push    = cmd_valid && cmd_ready && !abort;
  assign load_en = (state == ST_IDLE) && (state_nxt == ST_LOAD);
  assign lvl_nxt = abort ? '0 : level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};

  sm_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata (wdata),
    .rdata (rdata),
    .level (level)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE:  if (level != '0 && !hold) state_nxt = ST_LOAD;
      ST_LOAD: begin
        pop       = 1'b1;
        state_nxt = (gen_count != '0) ? ST_ARM : after_seg;
      end
      ST_ARM:   state_nxt = ST_RUN;
      ST_RUN:   if (gen_done) state_nxt = after_seg;
`ifdef SM_SEQ_DWELL_EN
      ST_DWELL: if (dwell_cnt <= DWELL_W'(1)) state_nxt = ST_IDLE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      pop       = 1'b0;
    end
  end

  // Generator fields are latched on entry to LOAD so gen_dir settles a full cycle before gen_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b0;
      gen_start  <= 1'b0;
      gen_stop   <= 1'b0;
      gen_period <= '0;
      gen_count  <= '0;
      gen_dir    <= 1'b0;
      seg_done   <= 1'b0;
      seq_busy   <= 1'b0;
      clamp_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= !abort && (lvl_nxt < FULL);
      seq_busy  <= (state_nxt != ST_IDLE) || (lvl_nxt != '0);
      gen_start <= (state == ST_LOAD) && (state_nxt == ST_ARM);
      gen_stop  <= abort && ((state == ST_ARM) || (state == ST_RUN && !gen_done));
      seg_done  <= (state == ST_RUN && gen_done) ||
                   (state == ST_LOAD && gen_count == '0 && !abort);
      if (load_en) begin
        gen_dir   <= head_dir;
        gen_count <= head_count;
        if (head_period < MIN_P) begin
          gen_period <= MIN_P;
          clamp_err  <= 1'b1;
        end else begin
          gen_period <= head_period;
        end
      end
    end
  end

`ifdef SM_SEQ_DWELL_EN
  // Counter tracks the latched dwell outside DWELL, so it is preloaded on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q   <= '0;
      dwell_cnt <= '0;
    end else begin
      if (load_en) dwell_q <= rdata[FW-1 -: DWELL_W];
      if (state != ST_DWELL) dwell_cnt <= dwell_q;
      else                   dwell_cnt <= dwell_cnt - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sm_move_sequencer.sv
// tb/tb_sm_move_sequencer.sv - scoreboard bench for sm_move_sequencer (either SM_SEQ_DWELL_EN build)
module tb_sm_move_sequencer;
  import sm_seq_pkg::*;

`ifdef SM_SEQ_DWELL_EN
  localparam int DW_EN = 1;
`else
  localparam int DW_EN = 0;
`endif
  localparam int GL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_dir, hold, abort;
  logic [15:0] cmd_period, cmd_count, cmd_dwell;
  logic        gen_start, gen_stop, gen_dir, gen_done, seg_done, seq_busy, clamp_err;
  logic [15:0] gen_period, gen_count;
  logic [2:0]  level;

  sm_move_sequencer #(.SIZE(16), .CNT_W(16), .DWELL_W(16), .DEPTH(4), .MIN_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_count(cmd_count), .cmd_dir(cmd_dir), .cmd_dwell(cmd_dwell),
    .hold(hold), .abort(abort), .gen_start(gen_start), .gen_stop(gen_stop),
    .gen_period(gen_period), .gen_count(gen_count), .gen_dir(gen_dir), .gen_done(gen_done),
    .seg_done(seg_done), .seq_busy(seq_busy), .clamp_err(clamp_err), .level(level)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int gen_lat = GL;
  bit killed;

  typedef struct {
    int cyc;
    int period;
    int count;
    int dir;
  } start_t;

  start_t exp_start[$];
  int     exp_seg[$];
  int     exp_stop[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic send(input int p, input int c, input int d, input int w, output int k);
    int b = 0;
    while (!cmd_ready && b < 50) begin
      tick();
      b++;
    end
    chk("cmd_ready before push", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_period = 16'(p);
    cmd_count  = 16'(c);
    cmd_dir    = d[0];
    cmd_dwell  = 16'(w);
    tick();
    k = cyc;
    cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    start_t e;
    int     c;
    if (rst_n) begin
      if (gen_start) begin
        if (exp_start.size() == 0) chk("unexpected gen_start", cyc, 0);
        else begin
          e = exp_start.pop_front();
          chk("gen_start cycle", cyc, e.cyc);
          chk("gen_period", gen_period, e.period);
          chk("gen_count", gen_count, e.count);
          chk("gen_dir", gen_dir, e.dir);
        end
      end
      if (seg_done) begin
        if (exp_seg.size() == 0) chk("unexpected seg_done", cyc, 0);
        else begin
          c = exp_seg.pop_front();
          chk("seg_done cycle", cyc, c);
        end
      end
      if (gen_stop) begin
        if (exp_stop.size() == 0) chk("unexpected gen_stop", cyc, 0);
        else begin
          c = exp_stop.pop_front();
          chk("gen_stop cycle", cyc, c);
        end
      end
    end
  end

  // Generator model: gen_done for one cycle gen_lat cycles after gen_start unless stopped.
  initial begin
    gen_done = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_start) begin
        killed = 1'b0;
        repeat (gen_lat - 1) begin
          @(negedge clk);
          if (gen_stop) killed = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!killed) gen_done = 1'b1;
        @(posedge clk);
        #1;
        gen_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, h, s;
    seq_cmd_t tab [4];
    cmd_valid = 1'b0; cmd_period = '0; cmd_count = '0; cmd_dir = 1'b0; cmd_dwell = '0;
    hold = 1'b0; abort = 1'b0;
    tab[0] = '{dwell: 16'd5, dir: 1'b0, count: 16'd5, period: 16'd20};
    tab[1] = '{dwell: 16'd5, dir: 1'b1, count: 16'd6, period: 16'd30};
    tab[2] = '{dwell: 16'd5, dir: 1'b0, count: 16'd7, period: 16'd40};
    tab[3] = '{dwell: 16'd5, dir: 1'b1, count: 16'd8, period: 16'd50};

    tick(2);
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset level", level, 0);
    chk("reset seq_busy", seq_busy, 0);
    chk("reset pulses/flags", {gen_start, gen_stop, seg_done, clamp_err, gen_dir}, 0);
    chk("reset gen_period", gen_period, 0);
    chk("reset gen_count", gen_count, 0);
    rst_n = 1'b1;
    tick();
    chk("cmd_ready after reset", cmd_ready, 1);

    // single command
    send(10, 3, 1, 0, k);
    exp_start.push_back('{k + 2, 10, 3, 1});
    exp_seg.push_back(k + 2 + GL + 1);
    chk("single level", level, 1);
    chk("single busy", seq_busy, 1);
    tick();
    chk("single dir before start", gen_dir, 1);
    chk("single no start in LOAD", gen_start, 0);
    wait_cyc(k + 12);
    chk("single idle", seq_busy, 0);
    chk("single period held", gen_period, 10);

    // four queued under hold, then released
    hold = 1'b1;
    for (int i = 0; i < 4; i++)
      send(tab[i].period, tab[i].count, tab[i].dir, tab[i].dwell, k);
    chk("full level", level, 4);
    chk("full cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("no push when full", level, 4);
    tick(3);
    h = cyc;
    hold = 1'b0;
    s = h + 2;
    for (int i = 0; i < 4; i++) begin
      exp_start.push_back('{s, tab[i].period, tab[i].count, tab[i].dir});
      exp_seg.push_back(s + GL + 1);
      s = s + GL + 3 + DW_EN * 5;
    end
    wait_cyc(s + 10);
    chk("queue drained", level, 0);
    chk("queue idle", seq_busy, 0);

    // period clamp boundary
    chk("clamp_err clear", clamp_err, 0);
    send(4, 1, 0, 0, k);
    exp_start.push_back('{k + 2, 4, 1, 0});
    exp_seg.push_back(k + 2 + GL + 1);
    wait_cyc(k + 12);
    chk("period at minimum no clamp", clamp_err, 0);
    send(2, 1, 0, 0, k);
    exp_start.push_back('{k + 2, 4, 1, 0});
    exp_seg.push_back(k + 2 + GL + 1);
    wait_cyc(k + 12);
    chk("clamp_err set", clamp_err, 1);
    send(7, 2, 1, 0, k);
    exp_start.push_back('{k + 2, 7, 2, 1});
    exp_seg.push_back(k + 2 + GL + 1);
    wait_cyc(k + 12);
    chk("clamp_err sticky", clamp_err, 1);
    chk("unclamped period", gen_period, 7);

    // abort while running with two queued
    gen_lat = 30;
    hold = 1'b1;
    send(11, 9, 1, 0, k);
    send(12, 9, 0, 0, k);
    send(13, 9, 1, 0, k);
    tick(2);
    h = cyc;
    hold = 1'b0;
    s = h + 2;
    exp_start.push_back('{s, 11, 9, 1});
    wait_cyc(s + 3);
    chk("abort level before", level, 2);
    abort = 1'b1;
    exp_stop.push_back(s + 4);
    tick();
    abort = 1'b0;
    chk("abort flushed", level, 0);
    chk("abort cmd_ready low", cmd_ready, 0);
    tick();
    chk("cmd_ready after abort", cmd_ready, 1);
    wait_cyc(s + 40);
    chk("abort idle", seq_busy, 0);

    // abort coincident with gen_done
    gen_lat = 6;
    hold = 1'b1;
    send(14, 2, 0, 0, k);
    send(15, 2, 1, 0, k);
    tick(2);
    h = cyc;
    hold = 1'b0;
    s = h + 2;
    exp_start.push_back('{s, 14, 2, 0});
    exp_seg.push_back(s + 7);
    wait_cyc(s + 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort+done flushed", level, 0);
    wait_cyc(s + 20);
    chk("abort+done idle", seq_busy, 0);

    // zero-count segment with dwell 3
    gen_lat = GL;
    send(12, 0, 1, 3, k);
    exp_seg.push_back(k + 2);
    tick();
    chk("zero count latched", gen_count, 0);
    chk("zero count dir latched", gen_dir, 1);
    wait_cyc(k + 1 + DW_EN * 3);
    chk("zero count busy", seq_busy, 1);
    tick();
    chk("zero count back idle", seq_busy, 0);

    tick(10);
    chk("pending gen_start", exp_start.size(), 0);
    chk("pending seg_done", exp_seg.size(), 0);
    chk("pending gen_stop", exp_stop.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
